// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue instruction fetch buffer, circular queue of
// {inst, pc}. Ports: fetch push (in_*), decoder pop (inst*/valid*/pc),
// flush, count; stall_cnt exists only with FQ_STALL_CNT_EN defined.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_cnt,
  input  logic [31:0]      in_instA,
  input  logic [31:0]      in_instB,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  input  logic             flush,
  output logic [31:0]      instA,
  output logic [31:0]      instB,
  output logic [31:0]      pc,
  output logic             validA,
  output logic             validB,
  input  logic             dec_ready,
`ifdef FQ_STALL_CNT_EN
  output logic [31:0]      stall_cnt,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    head1;
  logic [PW-1:0]    tail1;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic             va;
  logic             vb;
  logic             cnt_ok;

  assign head1 = head + PW'(1);
  assign tail1 = tail + PW'(1);

  // Second slot only pairs when it is the sequential successor;
  // otherwise it waits to become the head next cycle.
  assign va = (count_q >= CNT_W'(1));
  assign vb = (count_q >= CNT_W'(2))
           && (pc_q[head1] == pc_q[head] + 32'd4);

  assign validA = va;
  assign validB = vb;
  assign instA  = va ? inst_q[head]  : 32'd0;
  assign pc     = va ? pc_q[head]    : 32'd0;
  assign instB  = vb ? inst_q[head1] : 32'd0;
  assign count  = count_q;

  // Two free slots required even for a single, so the
  // fetch side never needs to look at in_cnt to decide.
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

  assign cnt_ok = (in_cnt == 2'd1) || (in_cnt == 2'd2);

  always_comb begin
    push_n = 2'd0;
    if (in_valid && in_ready && cnt_ok)
      push_n = in_cnt;
  end

  always_comb begin
    pop_n = 2'd0;
    if (dec_ready)
      pop_n = {1'b0, va} + {1'b0, vb};
  end

  assign count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PW'(pop_n);
      tail    <= tail + PW'(push_n);
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) begin
      inst_q[tail] <= in_instA;
      pc_q[tail]   <= in_pc;
      if (push_n == 2'd2) begin
        inst_q[tail1] <= in_instB;
        pc_q[tail1]   <= in_pc + 32'd4;
      end
    end
  end

`ifdef FQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (va && !dec_ready && !flush
             && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (DEPTH=8).
// Checks at the negative clock edge; inputs change there too.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_cnt;
  logic [31:0] in_instA;
  logic [31:0] in_instB;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic [31:0] instA;
  logic [31:0] instB;
  logic [31:0] pc;
  logic        validA;
  logic        validB;
  logic        dec_ready;
  logic [3:0]  count;
`ifdef FQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks;
  int failures;

  fetch_queue #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_cnt    (in_cnt),
    .in_instA  (in_instA),
    .in_instB  (in_instB),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .flush     (flush),
    .instA     (instA),
    .instB     (instB),
    .pc        (pc),
    .validA    (validA),
    .validB    (validB),
    .dec_ready (dec_ready),
`ifdef FQ_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v,
                       input logic [1:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] p);
    in_valid = v;
    in_cnt   = c;
    in_instA = a;
    in_instB = b;
    in_pc    = p;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic push_pkt(input int k);
    drive(1'b1, 2'd2,
          32'h1000_0000 + 32'(2 * k),
          32'h1000_0001 + 32'(2 * k),
          32'h0002_0000 + 32'(8 * k));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    dec_ready = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_validA", 32'(validA), 32'd0);
    chk("rst_validB", 32'(validB), 32'd0);
    chk("rst_instA", instA, 32'd0);
    chk("rst_instB", instB, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // pair push, no pop
    drive(1'b1, 2'd2, 32'h1230_0093,
          32'h0030_3093, 32'h0001_0000);
    tick();
    chk("p1_validA", 32'(validA), 32'd1);
    chk("p1_validB", 32'(validB), 32'd1);
    chk("p1_instA", instA, 32'h1230_0093);
    chk("p1_instB", instB, 32'h0030_3093);
    chk("p1_pc", pc, 32'h0001_0000);
    chk("p1_count", 32'(count), 32'd2);

    // pop two while pushing two
    drive(1'b1, 2'd2, 32'h0060_0093,
          32'h0020_81B3, 32'h0001_0008);
    dec_ready = 1'b1;
    tick();
    chk("p2_count", 32'(count), 32'd2);
    chk("p2_pc", pc, 32'h0001_0008);
    chk("p2_instA", instA, 32'h0060_0093);
    chk("p2_instB", instB, 32'h0020_81B3);
    chk("p2_validB", 32'(validB), 32'd1);

    idle();
    tick();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_validA", 32'(validA), 32'd0);

    // non-contiguous singles
    dec_ready = 1'b0;
    drive(1'b1, 2'd1, 32'h0000_0013, 32'hDEAD_BEEF,
          32'h0001_0000);
    tick();
    chk("s1_count", 32'(count), 32'd1);
    chk("s1_validB", 32'(validB), 32'd0);
    chk("s1_instB", instB, 32'd0);
    drive(1'b1, 2'd1, 32'h0000_0013, 32'hDEAD_BEEF,
          32'h0001_0010);
    tick();
    chk("s2_count", 32'(count), 32'd2);
    chk("s2_validA", 32'(validA), 32'd1);
    chk("s2_validB", 32'(validB), 32'd0);
    chk("s2_pc", pc, 32'h0001_0000);
    idle();
    dec_ready = 1'b1;
    tick();
    chk("s3_count", 32'(count), 32'd1);
    chk("s3_pc", pc, 32'h0001_0010);
    chk("s3_validA", 32'(validA), 32'd1);
    chk("s3_validB", 32'(validB), 32'd0);
    tick();
    chk("s4_count", 32'(count), 32'd0);

    // fill across the wrap (head=tail=6 here)
    dec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_pkt(k);
      tick();
    end
    chk("f_count6", 32'(count), 32'd6);
    chk("f_ready6", 32'(in_ready), 32'd1);
    push_pkt(3);
    dec_ready = 1'b1;
    tick();
    chk("f_pushpop_count", 32'(count), 32'd6);
    chk("f_pushpop_pc", pc, 32'h0002_0008);
    push_pkt(4);
    dec_ready = 1'b0;
    tick();
    chk("f_count8", 32'(count), 32'd8);
    chk("f_ready8", 32'(in_ready), 32'd0);
    push_pkt(5);
    tick();
    chk("f_reject_count", 32'(count), 32'd8);
    chk("f_reject_pc", pc, 32'h0002_0008);

    idle();
    dec_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("w_count", 32'(count), 32'(8 - 2 * (k - 1)));
      chk("w_pc", pc, 32'h0002_0000 + 32'(8 * k));
      chk("w_instA", instA, 32'h1000_0000 + 32'(2 * k));
      chk("w_instB", instB, 32'h1000_0001 + 32'(2 * k));
    end
    tick();
    chk("w_empty", 32'(count), 32'd0);

    // count=7 also refuses packets
    dec_ready = 1'b0;
    drive(1'b1, 2'd1, 32'h0000_0ABC, 32'd0,
          32'h0003_0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      push_pkt(10 + k);
      tick();
    end
    chk("c7_count", 32'(count), 32'd7);
    chk("c7_ready", 32'(in_ready), 32'd0);
    push_pkt(20);
    tick();
    chk("c7_reject", 32'(count), 32'd7);
    chk("c7_head", instA, 32'h0000_0ABC);

    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl1_count", 32'(count), 32'd0);
    chk("fl1_ready", 32'(in_ready), 32'd1);

    // count=5 then flush with push and pop
    push_pkt(30);
    tick();
    push_pkt(31);
    tick();
    drive(1'b1, 2'd1, 32'h0000_0055, 32'd0,
          32'h0004_0000);
    tick();
    chk("c5_count", 32'(count), 32'd5);
    push_pkt(40);
    dec_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl2_count", 32'(count), 32'd0);
    chk("fl2_validA", 32'(validA), 32'd0);
    chk("fl2_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl2_after", 32'(validA), 32'd0);

    // illegal in_cnt values are no push
    dec_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h1, 32'h2, 32'h0005_0000);
    tick();
    drive(1'b1, 2'd3, 32'h1, 32'h2, 32'h0005_0000);
    tick();
    chk("illegal_cnt", 32'(count), 32'd0);

    // async reset mid-operation
    push_pkt(50);
    tick();
    idle();
    chk("ar_pre", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_validA", 32'(validA), 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

`ifdef FQ_STALL_CNT_EN
    chk("st_rst", stall_cnt, 32'd0);
    push_pkt(60);
    tick();
    idle();
    chk("st_push", stall_cnt, 32'd0);
    repeat (10) tick();
    chk("st_ten", stall_cnt, 32'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("st_flush", stall_cnt, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("st_clear", stall_cnt, 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
